prn_ram_loader: RTL

//  Sequencer that fills the 1-bit PRN code RAMs of NCH correlator channels from a 32-bit word stream.

---
 rtl/prn_ram_pkg.sv | 22 ++
 rtl/prn_bit_unpacker.sv | 34 +++
 rtl/prn_ram_loader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/prn_ram_pkg.sv
// Shared types and constants for the PRN RAM loader slice.
// Latency: n/a (package only).
// Backpressure: n/a.
package prn_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } LOADER_STATE_T;

    localparam int          PRN_LEN_W  = 14;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One CRC-16-CCITT step, MSB-first, feeding a single data bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/prn_bit_unpacker.sv
// Purpose: holds one 32-bit code word and presents it LSB-first, one bit per shift.
// Latency: bit0 available the cycle after load; o_last marks the 32nd bit.
// Backpressure: none internally; caller decides when to load and shift.
module prn_bit_unpacker (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_load,
    input  logic        i_shift,
    input  logic [31:0] i_data,
    output logic        o_bit,
    output logic        o_last
);

    logic [31:0] r_sr;
    logic [4:0]  r_cnt;

    // Load a fresh word or step to the next bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_data;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr  <= r_sr >> 1;
            r_cnt <= r_cnt + 5'd1;
        end
    end

    assign o_bit  = r_sr[0];
    assign o_last = (r_cnt == 5'd31);

endmodule

// File: rtl/prn_ram_loader.sv
// Purpose: unpacks a 32-bit word stream into per-bit writes to one selected channel PRN RAM.
// Latency: registered outputs; a word takes 33 cycles (1 fetch + 32 writes). Optional CRC via PRN_RAM_LOADER_CRC_EN.
// Backpressure: s_ready only in FETCH; writes never stall, the word source is stalled instead.
module prn_ram_loader
    import prn_ram_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int RAM_SIZE = 10230,
    localparam int ADDR_BITS = $clog2(RAM_SIZE),
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CH_W-1:0]      ch_sel,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [PRN_LEN_W-1:0] length,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_data,
    output logic [NCH-1:0]       ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
`ifdef PRN_RAM_LOADER_CRC_EN
    ,
    output logic [15:0]          crc
`endif
);

    localparam logic [31:0]          RAM_SIZE_U = RAM_SIZE;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(RAM_SIZE - 1);

    LOADER_STATE_T r_state, w_next;

    logic [CH_W-1:0]      r_ch;
    logic [ADDR_BITS-1:0] r_addr;
    logic [PRN_LEN_W-1:0] r_rem;
    logic [NCH-1:0]       r_ram_we;
    logic [ADDR_BITS-1:0] r_ram_addr;
    logic                 r_ram_data;
    logic                 r_busy, r_done, r_err, r_s_ready;

    logic                 w_start_ok, w_load, w_write;
    logic                 w_bit, w_last, w_too_long;
    logic [ADDR_BITS-1:0] w_addr_nxt;
    logic [NCH-1:0]       w_onehot;

    assign w_too_long = ({18'd0, length} > RAM_SIZE_U);
    assign w_addr_nxt = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
    assign w_onehot   = NCH'(1) << r_ch;

    prn_bit_unpacker u_unpacker (
        .clk     (clk),
        .resetn  (resetn),
        .i_load  (w_load),
        .i_shift (w_write),
        .i_data  (s_data),
        .o_bit   (w_bit),
        .o_last  (w_last)
    );

    // Next-state decode; abort wins over any data movement in FETCH/SHIFT.
    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_load     = 1'b0;
        w_write    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_start_ok = 1'b1;
                    w_next     = (length == '0 || w_too_long) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    w_next = DONE;
                end else if (s_valid && r_s_ready) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_next = DONE;
                end else begin
                    w_write = 1'b1;
                    if (r_rem == 14'd1)
                        w_next = DONE;
                    else if (w_last)
                        w_next = FETCH;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Job context: channel, running address, bits remaining, sticky error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ch   <= '0;
            r_addr <= '0;
            r_rem  <= '0;
            r_err  <= 1'b0;
        end else if (w_start_ok) begin
            r_ch   <= ch_sel;
            r_addr <= base_addr;
            r_rem  <= length;
            r_err  <= w_too_long;
        end else begin
            if (abort && (r_state == FETCH || r_state == SHIFT))
                r_err <= 1'b1;
            if (w_write) begin
                r_addr <= w_addr_nxt;
                r_rem  <= r_rem - 14'd1;
            end
        end
    end

    // Registered RAM write port and status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ram_we   <= '0;
            r_ram_addr <= '0;
            r_ram_data <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_s_ready  <= 1'b0;
        end else begin
            r_ram_we <= w_write ? w_onehot : '0;
            if (w_write) begin
                r_ram_addr <= r_addr;
                r_ram_data <= w_bit;
            end
            r_busy    <= (w_next == FETCH) || (w_next == SHIFT);
            r_done    <= (w_next == DONE);
            r_s_ready <= (w_next == FETCH);
        end
    end

`ifdef PRN_RAM_LOADER_CRC_EN
    logic [15:0] r_crc;

    // Running CRC over every bit actually written in the current job.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         r_crc <= CRC16_INIT;
        else if (w_start_ok) r_crc <= CRC16_INIT;
        else if (w_write)    r_crc <= crc16_step(r_crc, w_bit);
    end

    assign crc = r_crc;
`endif

    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_data = r_ram_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign s_ready  = r_s_ready;

endmodule
